// File: rtl/simmem_wdata_tracker.sv
`default_nettype none
// ============================================================================
// Module      : simmem_wdata_tracker
// Description : Matches snooped write data beats to write address requests.
//               Early beats are counted, and pending addresses are queued.
// Revision    : 1.0 - initial release
// ============================================================================
module simmem_wdata_tracker #(
    parameter int IidW          = 6,
    parameter int BurstLenW     = 8,
    parameter int AddrDepth     = 8,
    parameter int MaxEarlyBeats = 64
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 waddr_valid_i,
    output logic                                 waddr_ready_o,
    input  logic [IidW-1:0]                      waddr_iid_i,
    input  logic [BurstLenW-1:0]                 waddr_burst_len_i,
    input  logic                                 core_waddr_ready_i,
    output logic [BurstLenW-1:0]                 waddr_immediate_cnt_o,
    input  logic                                 wdata_valid_i,
    output logic                                 wdata_ready_o,
    output logic                                 beat_valid_o,
    output logic [IidW-1:0]                      beat_iid_o,
    output logic                                 burst_done_valid_o,
    output logic [IidW-1:0]                      burst_done_iid_o,
    output logic [$clog2(MaxEarlyBeats+1)-1:0]   early_cnt_o,
    output logic [$clog2(AddrDepth+1)-1:0]       pending_cnt_o
);

    localparam int PtrW = $clog2(AddrDepth);
    localparam int CntW = $clog2(AddrDepth + 1);
    localparam int EW   = $clog2(MaxEarlyBeats + 1);
    localparam int CmpW = (EW > BurstLenW) ? EW : BurstLenW;

    localparam logic [CntW-1:0]      c_depth     = CntW'(AddrDepth);
    localparam logic [EW-1:0]        c_max_early = EW'(MaxEarlyBeats);
    localparam logic [PtrW-1:0]      c_last_ptr  = PtrW'(AddrDepth - 1);
    localparam logic [BurstLenW-1:0] c_one_beat  = BurstLenW'(1);

    logic [IidW-1:0]      r_iid_mem [AddrDepth];
    logic [BurstLenW-1:0] r_rem_mem [AddrDepth];
    logic [PtrW-1:0]      r_rd_ptr;
    logic [PtrW-1:0]      r_wr_ptr;
    logic [CntW-1:0]      r_count;
    logic [EW-1:0]        r_early;

    logic                 w_wa;
    logic                 w_wd;
    logic                 w_nonempty;
    logic                 w_len_zero;
    logic [IidW-1:0]      w_head_iid;
    logic [BurstLenW-1:0] w_head_rem;
    logic [EW-1:0]        w_avail;
    logic [CmpW-1:0]      w_avail_ext;
    logic [CmpW-1:0]      w_len_ext;
    logic                 w_covers;
    logic                 w_push;
    logic [BurstLenW-1:0] w_push_rem;
    logic                 w_pop;
    logic                 w_head_dec;
    logic [EW-1:0]        w_early_nxt;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == c_last_ptr) ? '0 : p + PtrW'(1);
    endfunction

    // Ready depends only on registered state so no combinational loop
    // through the requester is possible.
    assign waddr_ready_o = core_waddr_ready_i & (r_count < c_depth);
    assign wdata_ready_o = (r_count != '0) | (r_early < c_max_early);

    assign w_wa        = waddr_valid_i & waddr_ready_o;
    assign w_wd        = wdata_valid_i & wdata_ready_o;
    assign w_nonempty  = (r_count != '0);
    assign w_len_zero  = (waddr_burst_len_i == '0);
    assign w_head_iid  = r_iid_mem[r_rd_ptr];
    assign w_head_rem  = r_rem_mem[r_rd_ptr];
    assign w_avail     = r_early + EW'(w_wd);
    assign w_avail_ext = CmpW'(w_avail);
    assign w_len_ext   = CmpW'(waddr_burst_len_i);
    assign w_covers    = (w_avail_ext >= w_len_ext);

    assign early_cnt_o   = r_early;
    assign pending_cnt_o = r_count;

    always_comb begin
        w_push                = 1'b0;
        w_push_rem            = waddr_burst_len_i;
        w_pop                 = 1'b0;
        w_head_dec            = 1'b0;
        w_early_nxt           = r_early;
        beat_valid_o          = 1'b0;
        beat_iid_o            = '0;
        burst_done_valid_o    = 1'b0;
        burst_done_iid_o      = '0;
        waddr_immediate_cnt_o = '0;

        if (w_nonempty) begin
            if (w_wd) begin
                beat_valid_o = 1'b1;
                beat_iid_o   = w_head_iid;
                if (w_head_rem == c_one_beat) begin
                    w_pop              = 1'b1;
                    burst_done_valid_o = 1'b1;
                    burst_done_iid_o   = w_head_iid;
                end else begin
                    w_head_dec = 1'b1;
                end
            end
            if (w_wa && !w_len_zero) begin
                w_push = 1'b1;
            end
        end else begin
            w_early_nxt = w_avail;
            if (w_wa && !w_len_zero) begin
                if (w_covers) begin
                    waddr_immediate_cnt_o = waddr_burst_len_i;
                    burst_done_valid_o    = 1'b1;
                    burst_done_iid_o      = waddr_iid_i;
                    w_early_nxt           = EW'(w_avail_ext - w_len_ext);
                end else begin
                    waddr_immediate_cnt_o = BurstLenW'(w_avail_ext);
                    w_push                = 1'b1;
                    w_push_rem            = BurstLenW'(w_len_ext - w_avail_ext);
                    w_early_nxt           = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_early  <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
            r_early <= w_early_nxt;
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_iid_mem[r_wr_ptr] <= waddr_iid_i;
            r_rem_mem[r_wr_ptr] <= w_push_rem;
        end
        if (w_head_dec) begin
            r_rem_mem[r_rd_ptr] <= w_head_rem - c_one_beat;
        end
    end

    a_len_nonzero: assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_wa |-> !w_len_zero);

endmodule
`default_nettype wire

// File: tb/tb_simmem_wdata_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_simmem_wdata_tracker
// Description : Directed self-checking bench for simmem_wdata_tracker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simmem_wdata_tracker;

    logic       clk;
    logic       rst_n;
    logic       waddr_valid;
    logic [5:0] waddr_iid;
    logic [7:0] waddr_len;
    logic       core_ready;
    logic       wdata_valid;

    logic       m_waddr_ready, m_wdata_ready, m_beat_valid, m_done_valid;
    logic [7:0] m_imm;
    logic [5:0] m_beat_iid, m_done_iid;
    logic [6:0] m_early;
    logic [3:0] m_pending;

    logic       s_waddr_ready, s_wdata_ready, s_beat_valid, s_done_valid;
    logic [7:0] s_imm;
    logic [5:0] s_beat_iid, s_done_iid;
    logic [2:0] s_early;
    logic [1:0] s_pending;

    int n_cmp = 0;
    int n_err = 0;

    simmem_wdata_tracker u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .waddr_valid_i(waddr_valid), .waddr_ready_o(m_waddr_ready),
        .waddr_iid_i(waddr_iid), .waddr_burst_len_i(waddr_len),
        .core_waddr_ready_i(core_ready), .waddr_immediate_cnt_o(m_imm),
        .wdata_valid_i(wdata_valid), .wdata_ready_o(m_wdata_ready),
        .beat_valid_o(m_beat_valid), .beat_iid_o(m_beat_iid),
        .burst_done_valid_o(m_done_valid), .burst_done_iid_o(m_done_iid),
        .early_cnt_o(m_early), .pending_cnt_o(m_pending)
    );

    simmem_wdata_tracker #(.IidW(6), .BurstLenW(8), .AddrDepth(2), .MaxEarlyBeats(4)) u_small (
        .clk_i(clk), .rst_ni(rst_n),
        .waddr_valid_i(waddr_valid), .waddr_ready_o(s_waddr_ready),
        .waddr_iid_i(waddr_iid), .waddr_burst_len_i(waddr_len),
        .core_waddr_ready_i(core_ready), .waddr_immediate_cnt_o(s_imm),
        .wdata_valid_i(wdata_valid), .wdata_ready_o(s_wdata_ready),
        .beat_valid_o(s_beat_valid), .beat_iid_o(s_beat_iid),
        .burst_done_valid_o(s_done_valid), .burst_done_iid_o(s_done_iid),
        .early_cnt_o(s_early), .pending_cnt_o(s_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a cycle's inputs at the falling edge; outputs are then sampled 1ns later.
    task automatic set_in(input logic wv, input logic av, input logic [5:0] iid, input logic [7:0] len);
        @(negedge clk);
        wdata_valid = wv;
        waddr_valid = av;
        waddr_iid   = iid;
        waddr_len   = len;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wdata_valid = 1'b0;
        waddr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        core_ready = 1'b1; wdata_valid = 1'b0; waddr_valid = 1'b0;
        waddr_iid = '0; waddr_len = '0; rst_n = 1'b0;
        #2;
        n_cmp++; if (m_beat_valid !== 1'b0 || m_done_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_valids: beat=%b done=%b required 0 0", m_beat_valid, m_done_valid); end
        n_cmp++; if (m_beat_iid !== 6'd0 || m_done_iid !== 6'd0 || m_imm !== 8'd0) begin n_err++;
            $display("FAIL reset_payload: beat_iid=%0d done_iid=%0d imm=%0d required 0", m_beat_iid, m_done_iid, m_imm); end
        n_cmp++; if (m_early !== 7'd0 || m_pending !== 4'd0) begin n_err++;
            $display("FAIL reset_counts: early=%0d pending=%0d required 0 0", m_early, m_pending); end
        n_cmp++; if (m_wdata_ready !== 1'b1 || m_waddr_ready !== 1'b1) begin n_err++;
            $display("FAIL reset_ready: wdata=%b waddr=%b required 1 1", m_wdata_ready, m_waddr_ready); end
        core_ready = 1'b0; #1;
        n_cmp++; if (m_waddr_ready !== 1'b0) begin n_err++;
            $display("FAIL reset_waddr_ready_follows_core: got %b required 0", m_waddr_ready); end
        core_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_data_first();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 0, 0);
            n_cmp++; if (m_beat_valid !== 1'b0) begin n_err++;
                $display("FAIL df_early_beat_valid: got %b required 0", m_beat_valid); end
        end
        set_in(0, 0, 0, 0);
        n_cmp++; if (m_early !== 7'd3) begin n_err++;
            $display("FAIL df_early_cnt: got %0d required 3", m_early); end
        set_in(0, 1, 5, 3);
        n_cmp++; if (m_imm !== 8'd3 || m_done_valid !== 1'b1 || m_done_iid !== 6'd5) begin n_err++;
            $display("FAIL df_handshake: imm=%0d done=%b iid=%0d required 3 1 5", m_imm, m_done_valid, m_done_iid); end
        set_in(0, 0, 0, 0);
        n_cmp++; if (m_early !== 7'd0 || m_pending !== 4'd0 || m_done_valid !== 1'b0) begin n_err++;
            $display("FAIL df_after: early=%0d pending=%0d done=%b required 0 0 0", m_early, m_pending, m_done_valid); end
    endtask

    task automatic test_addr_first();
        set_in(0, 1, 2, 4);
        n_cmp++; if (m_imm !== 8'd0 || m_done_valid !== 1'b0) begin n_err++;
            $display("FAIL af_handshake: imm=%0d done=%b required 0 0", m_imm, m_done_valid); end
        set_in(0, 0, 0, 0);
        n_cmp++; if (m_pending !== 4'd1) begin n_err++;
            $display("FAIL af_pending: got %0d required 1", m_pending); end
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 0, 0);
            n_cmp++; if (m_beat_valid !== 1'b1 || m_beat_iid !== 6'd2) begin n_err++;
                $display("FAIL af_beat%0d: valid=%b iid=%0d required 1 2", i, m_beat_valid, m_beat_iid); end
            n_cmp++; if (m_done_valid !== (i == 3) || (i == 3 && m_done_iid !== 6'd2)) begin n_err++;
                $display("FAIL af_done%0d: done=%b iid=%0d required %0d 2", i, m_done_valid, m_done_iid, i == 3); end
        end
        set_in(0, 0, 0, 0);
        n_cmp++; if (m_pending !== 4'd0 || m_early !== 7'd0) begin n_err++;
            $display("FAIL af_after: pending=%0d early=%0d required 0 0", m_pending, m_early); end
    endtask

    task automatic test_simultaneous();
        set_in(1, 0, 0, 0);
        set_in(1, 1, 7, 4);
        n_cmp++; if (m_imm !== 8'd2 || m_done_valid !== 1'b0 || m_beat_valid !== 1'b0) begin n_err++;
            $display("FAIL sim_handshake: imm=%0d done=%b beat=%b required 2 0 0", m_imm, m_done_valid, m_beat_valid); end
        set_in(0, 0, 0, 0);
        n_cmp++; if (m_pending !== 4'd1 || m_early !== 7'd0) begin n_err++;
            $display("FAIL sim_state: pending=%0d early=%0d required 1 0", m_pending, m_early); end
        for (int i = 0; i < 2; i++) begin
            set_in(1, 0, 0, 0);
            n_cmp++; if (m_beat_valid !== 1'b1 || m_beat_iid !== 6'd7 || m_done_valid !== (i == 1)) begin n_err++;
                $display("FAIL sim_beat%0d: valid=%b iid=%0d done=%b required 1 7 %0d", i, m_beat_valid, m_beat_iid, m_done_valid, i == 1); end
        end
        set_in(0, 0, 0, 0);
        n_cmp++; if (m_pending !== 4'd0) begin n_err++;
            $display("FAIL sim_drained: pending=%0d required 0", m_pending); end
    endtask

    task automatic test_surplus_early();
        for (int i = 0; i < 5; i++) set_in(1, 0, 0, 0);
        set_in(0, 1, 1, 2);
        n_cmp++; if (m_imm !== 8'd2 || m_done_valid !== 1'b1 || m_done_iid !== 6'd1) begin n_err++;
            $display("FAIL sur_handshake: imm=%0d done=%b iid=%0d required 2 1 1", m_imm, m_done_valid, m_done_iid); end
        set_in(0, 0, 0, 0);
        n_cmp++; if (m_early !== 7'd3 || m_pending !== 4'd0) begin n_err++;
            $display("FAIL sur_state: early=%0d pending=%0d required 3 0", m_early, m_pending); end
    endtask

    task automatic test_backpressure_data();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(1, 0, 0, 0);
            n_cmp++; if (s_wdata_ready !== (i < 4)) begin n_err++;
                $display("FAIL bpd_ready%0d: got %b required %0d", i, s_wdata_ready, i < 4); end
        end
        set_in(0, 0, 0, 0);
        n_cmp++; if (s_early !== 3'd4) begin n_err++;
            $display("FAIL bpd_early: got %0d required 4", s_early); end
    endtask

    task automatic test_backpressure_addr();
        do_reset();
        set_in(0, 1, 1, 1);
        set_in(0, 1, 2, 1);
        n_cmp++; if (s_waddr_ready !== 1'b1) begin n_err++;
            $display("FAIL bpa_second_ready: got %b required 1", s_waddr_ready); end
        set_in(0, 0, 0, 0);
        n_cmp++; if (s_waddr_ready !== 1'b0 || s_pending !== 2'd2) begin n_err++;
            $display("FAIL bpa_full: ready=%b pending=%0d required 0 2", s_waddr_ready, s_pending); end
        set_in(1, 0, 0, 0);
        n_cmp++; if (s_beat_iid !== 6'd1 || s_done_valid !== 1'b1 || s_done_iid !== 6'd1 || s_waddr_ready !== 1'b0) begin n_err++;
            $display("FAIL bpa_pop1: iid=%0d done=%b done_iid=%0d ready=%b required 1 1 1 0", s_beat_iid, s_done_valid, s_done_iid, s_waddr_ready); end
        set_in(0, 0, 0, 0);
        n_cmp++; if (s_waddr_ready !== 1'b1 || s_pending !== 2'd1) begin n_err++;
            $display("FAIL bpa_freed: ready=%b pending=%0d required 1 1", s_waddr_ready, s_pending); end
        set_in(1, 0, 0, 0);
        n_cmp++; if (s_beat_iid !== 6'd2 || s_done_valid !== 1'b1 || s_done_iid !== 6'd2) begin n_err++;
            $display("FAIL bpa_pop2: iid=%0d done=%b done_iid=%0d required 2 1 2", s_beat_iid, s_done_valid, s_done_iid); end
        set_in(0, 0, 0, 0);
        n_cmp++; if (s_pending !== 2'd0) begin n_err++;
            $display("FAIL bpa_empty: pending=%0d required 0", s_pending); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        set_in(0, 1, 3, 2);
        set_in(0, 0, 0, 0);
        n_cmp++; if (m_pending !== 4'd1) begin n_err++;
            $display("FAIL rst_setup_pending: got %0d required 1", m_pending); end
        wdata_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (m_pending !== 4'd0 || m_early !== 7'd0 || m_beat_valid !== 1'b0 || m_done_valid !== 1'b0) begin n_err++;
            $display("FAIL rst_async: pending=%0d early=%0d beat=%b done=%b required 0 0 0 0", m_pending, m_early, m_beat_valid, m_done_valid); end
        n_cmp++; if (m_wdata_ready !== 1'b1 || m_waddr_ready !== 1'b1) begin n_err++;
            $display("FAIL rst_ready: wdata=%b waddr=%b required 1 1", m_wdata_ready, m_waddr_ready); end
        wdata_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        set_in(1, 0, 0, 0);
        n_cmp++; if (m_beat_valid !== 1'b0) begin n_err++;
            $display("FAIL rst_first_beat_valid: got %b required 0", m_beat_valid); end
        set_in(0, 0, 0, 0);
        n_cmp++; if (m_early !== 7'd1 || m_pending !== 4'd0) begin n_err++;
            $display("FAIL rst_first_beat_early: early=%0d pending=%0d required 1 0", m_early, m_pending); end
    endtask

    initial begin
        test_reset();
        test_data_first();
        test_addr_first();
        test_simultaneous();
        test_surplus_early();
        test_backpressure_data();
        test_backpressure_addr();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/simmem_wdata_tracker.md
# simmem_wdata_tracker

Parametrised write-data/address tracker sitting between the requester-side snoop and the delay calculator core. It matches each snooped write data beat to its write address request, whichever arrives first. Per address it reports the count of beats that arrived no later than the address, then forwards every later beat tagged with the owning internal identifier, and pulses a burst-done event tagged with that identifier. Early beats are held in a bounded counter with back-pressure, and pending addresses are held in a FIFO of configurable depth.

## Interface
- IidW, 6: internal write identifier width.
- BurstLenW, 8: burst length field width; burst length is a beat count, 1..2^BurstLenW-1.
- AddrDepth, 8: pending-address FIFO depth, ≥2.
- MaxEarlyBeats, 64: cap on beats held without an address, ≥1.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock, asynchronous, active-low.
- waddr_valid_i  in  1  write address valid.
- waddr_ready_o  out  1  write address ready.
- waddr_iid_i  in  IidW  iid of the address.
- waddr_burst_len_i  in  BurstLenW  beats in the burst.
- core_waddr_ready_i  in  1  downstream core can take an address.
- waddr_immediate_cnt_o  out  BurstLenW  beats credited to the address; meaningful on a waddr handshake.
- wdata_valid_i  in  1  write data valid.
- wdata_ready_o  out  1  write data ready.
- beat_valid_o  out  1  late beat forwarded.
- beat_iid_o  out  IidW  owner of the forwarded beat.
- burst_done_valid_o  out  1  a burst has all its beats.
- burst_done_iid_o  out  IidW  iid of the completed burst.
- early_cnt_o  out  $clog2(MaxEarlyBeats+1)  held early beats.
- pending_cnt_o  out  $clog2(AddrDepth+1)  FIFO occupancy.

## Operation
- State: early counter E; FIFO entries {iid, remaining}, where remaining ≥1. Invariant: E>0 implies the FIFO is empty.
- wa = waddr_valid_i & waddr_ready_o; wd = wdata_valid_i & wdata_ready_o.
- waddr_ready_o = core_waddr_ready_i & (pending_cnt < AddrDepth). A pop in the same cycle does not free a slot.
- wdata_ready_o = (pending_cnt > 0) | (E < MaxEarlyBeats).
- FIFO non-empty (so E=0):
  - wd decrements the head's remaining and drives beat_valid_o=1 with beat_iid_o = head iid.
  - If remaining reaches 0, the head is popped, with burst_done_valid_o=1 and burst_done_iid_o = head iid.
  - wa pushes {waddr_iid_i, len} to the tail, with waddr_immediate_cnt_o = 0.
- FIFO empty: let avail = E + wd.
  - On wa, imm = min(avail, len) and waddr_immediate_cnt_o = imm.
  - If imm == len: E ← avail − len, no push, and burst_done pulses with waddr_iid_i in the same cycle.
  - Else: push {iid, len − imm}, and E ← 0.
  - Without wa: E ← avail.
  - Early beats never assert beat_valid_o.
- At most one burst_done per cycle, because a same-cycle push never completes.
- burst_len = 0 is illegal. The address is still accepted, with no push, no done pulse and no change to E; a simulation assertion fires.
- Arithmetic is unsigned. avail ≤ MaxEarlyBeats by the ready rule, so nothing overflows. E saturates structurally through wdata_ready_o.

## Timing
- Reset values:
  - E = 0, FIFO empty.
  - beat_valid_o = 0, burst_done_valid_o = 0; iid outputs = 0.
  - waddr_immediate_cnt_o = 0, early_cnt_o = 0, pending_cnt_o = 0.
  - wdata_ready_o = 1; waddr_ready_o = core_waddr_ready_i.
- Latency is zero. beat_valid_o, burst_done_valid_o, their iids and waddr_immediate_cnt_o are combinational in the handshake cycle. State updates on the next posedge.
- The ready outputs depend only on registered state and core_waddr_ready_i. They never depend on the valid inputs.
- Valid and payload must stay stable until ready, per AXI. The block never drops a handshaken beat or address.
- Reset mid-operation clears E and the FIFO immediately (asynchronous). Partially matched bursts are discarded, and no done pulse is emitted for them.

## Test plan
- Data first:
  - Stimulus: 3 beats with no address (E=3), then an address {iid=5, len=3} with no beat.
  - Required: immediate_cnt=3, done pulse iid=5 in the same cycle, E=0, pending=0.
- Address first:
  - Stimulus: address {iid=2, len=4}, then 4 beats.
  - Required: immediate_cnt=0; beat_valid with iid=2 four times; done iid=2 on the 4th beat; pending goes 1→0.
- Simultaneous with partial early:
  - Stimulus: E=1, then the same cycle carries a beat and address {iid=7, len=4}.
  - Required: immediate_cnt=2, push {7, 2}, E=0. Two further beats are tagged iid=7, and done fires on the second.
- Surplus early:
  - Stimulus: E=5, address {iid=1, len=2}.
  - Required: immediate_cnt=2, done iid=1, E=3.
- Back-pressure:
  - Stimulus: MaxEarlyBeats=4 with 5 beats offered.
  - Required: wdata_ready_o goes low after the 4th beat.
  - Stimulus: AddrDepth=2, two addresses of len=1 with no data.
  - Required: waddr_ready_o=0; a beat pops the head, ready returns the next cycle, and the FIFO order is preserved.
- Reset mid-burst:
  - Stimulus: pending={3, 2}, then rst_ni low.
  - Required: all outputs take their reset values immediately; after release, the first beat raises E to 1 and no beat_valid is asserted.
